seq_shift_unit: RTL and testbench
=================================

// Module: seq_shift_unit
// PURPOSE
//  Multi-cycle, parametrised shift/rotate execution unit for the datapath ALU (shl/shr/shra/rol/ror).
//  Takes operand A (Y register) and shift amount B (bus) on a start pulse and shifts STEP bits per clock.
//  Result feeds the Z register path; start/done handshake lets the control unit hold T-states until done.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (power of two, >= 8)
//  STEP    1   bits shifted per clock (power of two, 1..WIDTH)
//  CNT_W   $clog2(WIDTH)  derived; width of shift-amount counter (localparam)
// PORTS
//  clk      in   1        system clock, rising edge
//  clr      in   1        asynchronous active-high reset
//  start    in   1        request; sampled only in IDLE
//  op       in   3        000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, others illegal
//  a        in   WIDTH    operand to shift
//  b        in   WIDTH    shift amount; only b[CNT_W-1:0] used (amount mod WIDTH)
//  busy     out  1        high whenever state != IDLE
//  done     out  1        one-cycle pulse, result valid
//  result   out  WIDTH    shifted value; held from done until next accepted start
// BEHAVIOUR
//  Reset (clr=1, async): state=IDLE, busy=0, done=0, result=0, internal regs=0; mid-operation abort, no done.
//  Clock and reset are decided: one clock; reset is asynchronous and active-high (clk, clr).
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 latches a, op, amt=b[CNT_W-1:0]; amt!=0 and op legal -> SHIFT, else -> DONE.
//   SHIFT: each edge shifts working reg by s=min(STEP,rem); rem-=s; rem==s at edge -> DONE.
//   DONE: done=1, result<=working reg (written on entry edge); next edge -> IDLE.
//  Latency: start accepted at edge 0; done high in cycle ceil(amt/STEP)+1. amt=0 or illegal op: cycle 1.
//  start while busy (SHIFT or DONE) ignored; inputs need not be held after accept.
//  SHL/SHR fill 0; SHRA replicates a[WIDTH-1]; ROL/ROR wrap bits end-to-end.
//  Illegal op: result=a unchanged, normal done pulse.
//  amt >= WIDTH impossible by truncation (b=0x25, WIDTH=32 -> amt=5).
//  result updates only on DONE entry; holds during a following SHIFT.
// CONFIGURATION
//  SEQ_SHIFT_FLAGS_EN defined: adds outputs carry (1) and zero (1), same timing as result, reset 0.
//   carry = last bit shifted out (shifts) or last bit wrapped (rotates); 0 when amt=0 or illegal op.
//   zero = (result == 0).
//  Undefined: carry/zero ports and logic absent; all other behaviour identical.
// STRUCTURE
//  cpu_pkg: op encodings (OP_SHL..OP_ROR), state enum (ST_IDLE/ST_SHIFT/ST_DONE).
//  One combinational sub-module natural: shift_step (WIDTH, STEP) -> shifts by s<=STEP for given op.
//  Top holds FSM, remaining counter, working register, result/flag registers.
// TESTING
//  T1 WIDTH=32 STEP=1: SHL a=0x1, b=0x2 -> done cycle 3, result=0x00000004, busy cycles 1-3.
//  T2 SHRA a=0x80000000, b=4 -> result=0xF8000000; SHR same -> 0x08000000.
//  T3 ROR a=0x1, b=0x21 (amt=1) -> result=0x80000000, done cycle 2; flags: carry=1, zero=0.
//  T4 b=0 or op=3'b111, a=0xDEADBEEF -> done cycle 1, result=0xDEADBEEF; start during busy ignored.
//  T5 clr asserted in SHIFT mid-way (SHL b=20) -> busy/done/result=0 immediately; next start works.
//  T6 STEP=4: ROL a=0x12345678, b=8 -> done cycle 3, result=0x34567812; b=6 -> done cycle 3.

Source files
------------

// File: rtl/seq_shift_unit_pkg.sv
// seq_shift_unit_pkg
//   Shared definitions for the sequential shift/rotate unit:
//   op encodings, FSM state encoding and an op-legality helper.
package seq_shift_unit_pkg;

    typedef enum logic [2:0] {
        OP_SHL  = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHRA = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Encodings above OP_ROR are illegal; they pass the operand through.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if
//   Request/response bundle of the shift unit.
//   master (control unit): drives start, op, a, b; observes busy, done, result.
//   slave  (shift unit)  : the reverse.
//   With SEQ_SHIFT_FLAGS_EN defined the bundle also carries carry and zero.
interface seq_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SEQ_SHIFT_FLAGS_EN
    logic             carry;
    logic             zero;

    modport master (output start, op, a, b, input busy, done, result, carry, zero);
    modport slave  (input start, op, a, b, output busy, done, result, carry, zero);
`else
    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
`endif
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// seq_shift_unit_shift_step
//   Combinational stage: shifts/rotates din by amt bits (0..STEP) for the given op.
//   Ports:
//     op   in  3             operation encoding
//     din  in  WIDTH         value to shift
//     amt  in  $clog2(W)+1   bits to shift this cycle, never above STEP
//     dout out WIDTH         shifted value
//     cout out 1             last bit shifted out / wrapped (0 when amt=0)
module seq_shift_unit_shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH):0]   amt,
    output logic [WIDTH-1:0]         dout,
    output logic                     cout
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] t;
    logic             c;

    // Unrolled chain of single-bit moves; stages beyond amt are bypassed.
    // The carry simply tracks the bit that crossed the edge in the last active stage.
    always_comb begin
        t = din;
        c = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (AW'(i) < amt) begin
                case (op)
                    OP_SHL:  begin c = t[WIDTH-1]; t = {t[WIDTH-2:0], 1'b0};       end
                    OP_SHR:  begin c = t[0];       t = {1'b0, t[WIDTH-1:1]};       end
                    OP_SHRA: begin c = t[0];       t = {t[WIDTH-1], t[WIDTH-1:1]}; end
                    OP_ROL:  begin c = t[WIDTH-1]; t = {t[WIDTH-2:0], t[WIDTH-1]}; end
                    OP_ROR:  begin c = t[0];       t = {t[0], t[WIDTH-1:1]};       end
                    default: ;
                endcase
            end
        end
    end

    assign dout = t;
    assign cout = c;

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle shift/rotate unit (SHL/SHR/SHRA/ROL/ROR), STEP bits per clock.
//   Ports:
//     clk  in  rising-edge clock
//     clr  in  asynchronous active-high reset
//     bus  slave modport of seq_shift_unit_if:
//          start/op/a/b in, busy/done/result out
//          (+ carry/zero out when SEQ_SHIFT_FLAGS_EN is defined)
//   Optional feature macro: SEQ_SHIFT_FLAGS_EN (carry and zero flags).
//   Flow: IDLE -> SHIFT -> DONE -> IDLE. A zero amount or illegal op goes
//   straight to DONE with the operand unchanged. result only changes on
//   DONE entry and holds through later operations until the next DONE.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic            clk,
    input  logic            clr,
    seq_shift_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int AW    = CNT_W + 1;

    state_e             state_q;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   rem_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
`ifdef SEQ_SHIFT_FLAGS_EN
    logic               carry_q;
    logic               zero_q;
`endif

    logic [CNT_W-1:0]   amt_in;
    logic [AW-1:0]      step_amt;
    logic               last_step;
    logic [WIDTH-1:0]   work_d;
    logic               carry_d;

    assign amt_in = bus.b[CNT_W-1:0];

    // Shift by min(STEP, remaining); the final step may be partial.
    assign step_amt  = ({1'b0, rem_q} >= AW'(STEP)) ? AW'(STEP) : {1'b0, rem_q};
    assign last_step = ({1'b0, rem_q} == step_amt);

    seq_shift_unit_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op   (op_q),
        .din  (work_q),
        .amt  (step_amt),
        .dout (work_d),
        .cout (carry_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rem_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_SHIFT_FLAGS_EN
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        rem_q  <= amt_in;
                        work_q <= bus.a;
                        busy_q <= 1'b1;
                        if (amt_in != '0 && op_legal(bus.op)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            // Nothing to shift: publish the operand as-is.
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.a;
`ifdef SEQ_SHIFT_FLAGS_EN
                            carry_q  <= 1'b0;
                            zero_q   <= (bus.a == '0);
`endif
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_q - step_amt[CNT_W-1:0];
                    if (last_step) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= work_d;
`ifdef SEQ_SHIFT_FLAGS_EN
                        carry_q  <= carry_d;
                        zero_q   <= (work_d == '0);
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
`ifdef SEQ_SHIFT_FLAGS_EN
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;

    logic unused_ok;
    assign unused_ok = ^bus.b[WIDTH-1:CNT_W];
`else
    logic unused_ok;
    assign unused_ok = ^{bus.b[WIDTH-1:CNT_W], carry_d};
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit
//   Two instances (STEP=1 and STEP=4, WIDTH=32) checked against an
//   arithmetic reference of the shift/rotate rules and latency formula.
module tb_seq_shift_unit;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_shift_unit_if #(.WIDTH(32)) if1 ();
    seq_shift_unit_if #(.WIDTH(32)) if4 ();

    seq_shift_unit #(.WIDTH(32), .STEP(1)) u1 (.clk(clk), .clr(clr), .bus(if1));
    seq_shift_unit #(.WIDTH(32), .STEP(4)) u4 (.clk(clk), .clr(clr), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [2:0] o,
                         input logic [31:0] aa, input logic [31:0] bb);
        if (sel == 4) begin
            if4.start = s; if4.op = o; if4.a = aa; if4.b = bb;
        end else begin
            if1.start = s; if1.op = o; if1.a = aa; if1.b = bb;
        end
    endtask

    function automatic logic rd_busy(input int sel);
        return (sel == 4) ? if4.busy : if1.busy;
    endfunction
    function automatic logic rd_done(input int sel);
        return (sel == 4) ? if4.done : if1.done;
    endfunction
    function automatic logic [31:0] rd_res(input int sel);
        return (sel == 4) ? if4.result : if1.result;
    endfunction

    // Reference: the whole shift in one arithmetic step.
    function automatic logic [31:0] m_res(input logic [2:0] o, input logic [31:0] x, input int n);
        if (n == 0 || o > 3'd4) return x;
        case (o)
            3'd0:    return x << n;
            3'd1:    return x >> n;
            3'd2:    return 32'($signed(x) >>> n);
            3'd3:    return (x << n) | (x >> (32 - n));
            default: return (x >> n) | (x << (32 - n));
        endcase
    endfunction

`ifdef SEQ_SHIFT_FLAGS_EN
    function automatic logic m_carry(input logic [2:0] o, input logic [31:0] x, input int n);
        logic [31:0] r;
        r = m_res(o, x, n);
        if (n == 0 || o > 3'd4) return 1'b0;
        case (o)
            3'd0:    return x[32-n];
            3'd1,
            3'd2:    return x[n-1];
            3'd3:    return r[0];
            default: return r[31];
        endcase
    endfunction
    function automatic logic rd_carry(input int sel);
        return (sel == 4) ? if4.carry : if1.carry;
    endfunction
    function automatic logic rd_zero(input int sel);
        return (sel == 4) ? if4.zero : if1.zero;
    endfunction
`endif

    // One operation: start at edge 0, watch each cycle until done, then
    // check the idle cycle that follows. poke=1 pulses a bogus start in cycle 1.
    task automatic run(input int sel, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input bit poke);
        int          n, lat;
        bit          got;
        logic [31:0] exp;
        n   = int'(bb[4:0]);
        exp = m_res(o, aa, n);
        lat = (n == 0 || o > 3'd4) ? 1 : (n + sel - 1) / sel + 1;
        got = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, o, aa, bb);
        @(posedge clk);
        #1 drive(sel, 1'b0, 3'($urandom), $urandom, $urandom);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            chk($sformatf("busy s%0d c%0d", sel, cyc), 32'(rd_busy(sel)), 32'(cyc <= lat));
            if (rd_done(sel)) begin
                got = 1'b1;
                chk($sformatf("lat s%0d op%0d n%0d", sel, o, n), cyc, lat);
                chk($sformatf("res s%0d op%0d a%h n%0d", sel, o, aa, n), rd_res(sel), exp);
`ifdef SEQ_SHIFT_FLAGS_EN
                chk("carry", 32'(rd_carry(sel)), 32'(m_carry(o, aa, n)));
                chk("zero", 32'(rd_zero(sel)), 32'(exp == 32'd0));
`endif
            end
            if (poke && cyc == 1) begin
                drive(sel, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd3);
                @(posedge clk);
                #1 drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
            end
        end
        if (!got) chk("done timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("idle busy", 32'(rd_busy(sel)), 32'd0);
        chk("idle done", 32'(rd_done(sel)), 32'd0);
        chk("held result", rd_res(sel), exp);
    endtask

    initial begin
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(4, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(if1.busy), 32'd0);
        chk("rst done", 32'(if1.done), 32'd0);
        chk("rst result", if1.result, 32'd0);
        chk("rst result4", if4.result, 32'd0);
`ifdef SEQ_SHIFT_FLAGS_EN
        chk("rst carry", 32'(if1.carry), 32'd0);
        chk("rst zero", 32'(if1.zero), 32'd0);
`endif
        clr = 1'b0;

        // Directed cases
        run(1, 3'd0, 32'h0000_0001, 32'h2, 1'b0);          // SHL by 2
        run(1, 3'd2, 32'h8000_0000, 32'h4, 1'b0);          // SHRA
        run(1, 3'd1, 32'h8000_0000, 32'h4, 1'b0);          // SHR
        run(1, 3'd4, 32'h0000_0001, 32'h21, 1'b1);         // ROR, amount truncated, busy poke
        run(1, 3'd0, 32'hDEAD_BEEF, 32'h0, 1'b1);          // zero amount
        run(1, 3'd7, 32'hDEAD_BEEF, 32'h5, 1'b1);          // illegal op
        run(1, 3'd3, 32'h8000_0001, 32'h1F, 1'b0);         // max amount
        run(4, 3'd3, 32'h1234_5678, 32'h8, 1'b0);          // ROL STEP=4
        run(4, 3'd3, 32'h1234_5678, 32'h6, 1'b1);          // partial last step
        run(4, 3'd2, 32'h8765_4321, 32'h1F, 1'b0);
        run(4, 3'd5, 32'hCAFE_F00D, 32'h9, 1'b0);

        // Abort mid-shift
        @(negedge clk);
        drive(1, 1'b1, 3'd0, 32'h0000_0001, 32'd20);
        @(posedge clk);
        #1 drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("abort busy", 32'(if1.busy), 32'd0);
        chk("abort done", 32'(if1.done), 32'd0);
        chk("abort result", if1.result, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        run(1, 3'd0, 32'h0000_0003, 32'd20, 1'b0);

        // Random sweep on both instances
        for (int k = 0; k < 40; k++) begin
            run((k % 2 == 0) ? 1 : 4, 3'($urandom_range(0, 7)), $urandom, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
